// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU (ADD, SUB, MUL, DIV, EXP) with a start/busy/done handshake.
// MUL and EXP use an iterative shift-add multiplier. DIV uses restoring division.
// Both work on operand magnitudes, and the sign is applied in the FIX state.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; aborts any operation without a done pulse
//   start   request; accepted when start=1 and busy=0 (IDLE or DONE state)
//   op      000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 EXP, others invalid
//   a, b    signed WIDTH-bit operands, captured at acceptance
//   busy    high while an accepted operation is in flight
//   done    one-cycle pulse; result/rem/ovf are valid from this cycle
//   result  signed 2*WIDTH-bit result, held until the next done
//   rem     signed remainder (DIV only, else 0)
//   ovf     overflow/error flag, held with result
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     rem,
  output logic                 ovf
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned W3   = 3 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpExp = 3'b100;

  localparam logic [W2-1:0] One2    = {{(W2-1){1'b0}}, 1'b1};
  // Magnitude 2^(2W-1): the only out-of-positive-range value that is still a legal negative
  // result.
  localparam logic [W3-1:0] MinMag  = {{WIDTH{1'b0}}, 1'b1, {(W2-1){1'b0}}};
  localparam logic [CntW-1:0] LastIt = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMulIt, StDivIt, StExpIt, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  // Working product/quotient register: {hi, lo}.
  logic [W2-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  pass_q, pass_d;
  logic [W2-1:0]     result_q, result_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              ovf_q, ovf_d;

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [W2-1:0] mag_2w(input logic [W2-1:0] v);
    return v[W2-1] ? -v : v;
  endfunction

  // One shift-add multiply step.
  logic [W2:0]       add_sum;
  logic [W2-1:0]     mul_hi;
  logic [WIDTH-1:0]  mul_lo;
  logic [W3-1:0]     prod;
  // One restoring-divide step.
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH-1:0]  trial;
  logic              div_ge;
  // End-of-pass EXP update.
  logic              exp_neg, exp_fits;
  logic [W2-1:0]     exp_acc;
  // FIX-state helpers.
  logic [W2-1:0]     a_ext, b_ext, mul_mag, quo;
  logic              sign_neg;
  logic              last_it;

  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi   = add_sum[W2:1];
    mul_lo   = {add_sum[0], lo_q[WIDTH-1:1]};
    prod     = {mul_hi, mul_lo};

    rem_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, mcand_q[WIDTH-1:0]};
    trial    = rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];

    exp_neg  = acc_q[W2-1] ^ a_q[WIDTH-1];
    exp_fits = (prod[W3-1:W2-1] == '0) || (exp_neg && (prod == MinMag));
    exp_acc  = exp_neg ? -prod[W2-1:0] : prod[W2-1:0];

    a_ext    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    mul_mag  = {hi_q[WIDTH-1:0], lo_q};
    quo      = {{WIDTH{1'b0}}, lo_q};
    sign_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    last_it  = (cnt_q == LastIt);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          err_d = 1'b0;
          acc_d = One2;
          cnt_d = '0;
          hi_d  = '0;
          // Single-step ops still pass through FIX so that done lands one edge after acceptance.
          state_d = StFix;
          case (op)
            OpMul: begin
              mcand_d = {{WIDTH{1'b0}}, mag_w(a)};
              lo_d    = mag_w(b);
              state_d = StMulIt;
            end
            OpDiv: begin
              mcand_d = {{WIDTH{1'b0}}, mag_w(b)};
              lo_d    = mag_w(a);
              state_d = StDivIt;
            end
            OpExp: begin
              if (!b[WIDTH-1] && (b != '0)) begin
                mcand_d = One2;
                lo_d    = mag_w(a);
                pass_d  = b;
                state_d = StExpIt;
              end
            end
            default: ;
          endcase
        end
      end

      StMulIt: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CntW'(1);
        if (last_it) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end

      StDivIt: begin
        hi_d  = {{WIDTH{1'b0}}, (div_ge ? trial : rem_sh[WIDTH-1:0])};
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CntW'(1);
        if (last_it) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end

      StExpIt: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CntW'(1);
        if (last_it) begin
          // Keep the wrapped product; later passes stay correct modulo 2^(2W).
          acc_d  = exp_acc;
          err_d  = err_q | ~exp_fits;
          pass_d = pass_q - WIDTH'(1);
          cnt_d  = '0;
          if (pass_q == WIDTH'(1)) begin
            state_d = StFix;
          end else begin
            hi_d    = '0;
            lo_d    = mag_w(a_q);
            mcand_d = mag_2w(exp_acc);
          end
        end
      end

      StFix: begin
        state_d  = StDone;
        result_d = '0;
        rem_d    = '0;
        ovf_d    = 1'b0;
        case (op_q)
          OpAdd: result_d = a_ext + b_ext;
          OpSub: result_d = a_ext - b_ext;
          OpMul: result_d = sign_neg ? -mul_mag : mul_mag;
          OpDiv: begin
            if (b_q == '0) begin
              ovf_d = 1'b1;
            end else begin
              result_d = sign_neg ? -quo : quo;
              rem_d    = a_q[WIDTH-1] ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
            end
          end
          OpExp: begin
            if (b_q == '0) begin
              result_d = One2;
            end else if (b_q[WIDTH-1]) begin
              // Negative exponent: only +-1 have non-zero integer results; 0^-n is an error.
              if (a_q == WIDTH'(1)) begin
                result_d = One2;
              end else if (a_q == '1) begin
                result_d = b_q[0] ? '1 : One2;
              end else if (a_q == '0) begin
                ovf_d = 1'b1;
              end
            end else begin
              result_d = acc_q;
              ovf_d    = err_q;
            end
          end
          default: ovf_d = 1'b1;
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      pass_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign rem    = rem_q;
  assign ovf    = ovf_q;

endmodule
